// File: rtl/frame_writer_pkg.sv
// Shared encodings for the ping-pong frame writer: bank states, writer states
// and the offset bit-reverse helper used when FRAME_WRITER_BITREV_EN is defined.
package frame_writer_pkg;

    typedef enum logic [1:0] {
        BankFree    = 2'd0,
        BankFilling = 2'd1,
        BankFull    = 2'd2
    } bank_st_e;

    typedef enum logic {
        StWrite = 1'b0,
        StStall = 1'b1
    } wr_st_e;

    // Reverse the low 'width' bits of value; bits above width come back as zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value,
                                                input int unsigned width);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(width)) begin
                result[int'(width) - 1 - i] = value[i];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/frame_writer.sv
// Ping-pong frame writer sitting directly in front of a two-bank unitRAM.
// Samples stream into one bank until it is full, then the writer flips to the
// other bank or stalls (s_ready=0) until the consumer releases a bank.
// Define FRAME_WRITER_BITREV_EN to write offsets in bit-reversed (FFT input) order.
module frame_writer
    import frame_writer_pkg::*;
#(
    parameter int unsigned word_width    = 4,
    parameter int unsigned address_width = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [word_width-1:0]    s_data,
    output logic                     wr_en,
    output logic [address_width-1:0] wr_address,
    output logic [word_width-1:0]    wr_data,
    output logic                     frame_valid,
    output logic                     frame_bank,
    input  logic                     frame_release
);

    localparam int unsigned OffW = address_width - 1;

    bank_st_e                 bank_q [2];
    bank_st_e                 bank_d [2];
    wr_st_e                   st_q, st_d;
    logic                     wr_bank_q, wr_bank_d;
    logic [OffW-1:0]          off_q, off_d;
    logic [OffW-1:0]          off_out;
    logic                     wr_en_q;
    logic [address_width-1:0] wr_addr_q;
    logic [word_width-1:0]    wr_data_q;
    logic                     full0, full1, fb, xfer, rel;

    // Consumer-facing status, derived from registered bank state only.
    always_comb begin
        full0   = (bank_q[0] == BankFull);
        full1   = (bank_q[1] == BankFull);
        // Both full only happens in STALL, where wr_bank_q names the blocked
        // (older) bank; otherwise the single full bank is the one presented.
        fb      = (full0 && full1) ? wr_bank_q : full1;
        s_ready = (st_q == StWrite);
        xfer    = s_valid && s_ready;
        rel     = frame_release && (full0 || full1);
    end

    // Bank bookkeeping and writer next state; release is applied before the
    // transfer so a same-cycle release frees the bank the writer flips into.
    always_comb begin
        bank_d    = bank_q;
        st_d      = st_q;
        wr_bank_d = wr_bank_q;
        off_d     = off_q;
        if (rel) begin
            bank_d[fb] = BankFree;
            if (st_q == StStall) begin
                st_d  = StWrite;
                off_d = '0;
            end
        end
        if (xfer) begin
            if (&off_q) begin
                bank_d[wr_bank_q] = BankFull;
                off_d             = '0;
                wr_bank_d         = ~wr_bank_q;
                st_d              = (bank_d[~wr_bank_q] == BankFree) ? StWrite : StStall;
            end else begin
                bank_d[wr_bank_q] = BankFilling;
                off_d             = off_q + 1'b1;
            end
        end
    end

    // Physical offset ordering within a bank.
    always_comb begin
`ifdef FRAME_WRITER_BITREV_EN
        off_out = OffW'(bit_reverse(32'(off_q), OffW));
`else
        off_out = off_q;
`endif
    end

    // State and registered RAM write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0] <= BankFree;
            bank_q[1] <= BankFree;
            st_q      <= StWrite;
            wr_bank_q <= 1'b0;
            off_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            st_q      <= st_d;
            wr_bank_q <= wr_bank_d;
            off_q     <= off_d;
            wr_en_q   <= xfer;
            if (xfer) begin
                wr_addr_q <= {wr_bank_q, off_out};
                wr_data_q <= s_data;
            end
        end
    end

    // Output mapping.
    always_comb begin
        wr_en       = wr_en_q;
        wr_address  = wr_addr_q;
        wr_data     = wr_data_q;
        frame_valid = full0 || full1;
        frame_bank  = fb;
    end

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer (word_width=4, address_width=3, FRAME=4).
// Expected addresses follow FRAME_WRITER_BITREV_EN when it is defined.
module tb_frame_writer;

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] s_data;
    logic       wr_en;
    logic [2:0] wr_address;
    logic [3:0] wr_data;
    logic       frame_valid;
    logic       frame_bank;
    logic       frame_release;

    int total;
    int bad;

    frame_writer #(
        .word_width   (4),
        .address_width(3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .wr_en        (wr_en),
        .wr_address   (wr_address),
        .wr_data      (wr_data),
        .frame_valid  (frame_valid),
        .frame_bank   (frame_bank),
        .frame_release(frame_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected RAM address for a bank/offset pair.
    function automatic logic [2:0] ea(input logic bank, input logic [1:0] off);
`ifdef FRAME_WRITER_BITREV_EN
        return {bank, off[0], off[1]};
`else
        return {bank, off};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accepted transfer, checked on the registered write port after the edge.
    task automatic send(input logic [3:0] d, input logic [2:0] addr);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("send_wr_en", 32'(wr_en), 1);
        chk("send_addr", 32'(wr_address), 32'(addr));
        chk("send_data", 32'(wr_data), 32'(d));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("idle_wr_en", 32'(wr_en), 0);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        s_valid       = 1'b0;
        s_data        = '0;
        frame_release = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_addr", 32'(wr_address), 0);
        chk("rst_data", 32'(wr_data), 0);
        chk("rst_fvalid", 32'(frame_valid), 0);
        chk("rst_fbank", 32'(frame_bank), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(s_ready), 1);

        // First frame into bank 0
        send(4'd1, ea(1'b0, 2'd0));
        send(4'd2, ea(1'b0, 2'd1));
        send(4'd3, ea(1'b0, 2'd2));
        chk("f0_not_yet_valid", 32'(frame_valid), 0);
        send(4'd4, ea(1'b0, 2'd3));
        chk("f0_valid", 32'(frame_valid), 1);
        chk("f0_bank", 32'(frame_bank), 0);
        chk("f0_ready", 32'(s_ready), 1);

        // Second frame into bank 1, then stall with both banks full
        send(4'd5, ea(1'b1, 2'd0));
        send(4'd6, ea(1'b1, 2'd1));
        send(4'd7, ea(1'b1, 2'd2));
        send(4'd8, ea(1'b1, 2'd3));
        chk("stall_ready", 32'(s_ready), 0);
        chk("stall_fvalid", 32'(frame_valid), 1);
        chk("stall_fbank_oldest", 32'(frame_bank), 0);
        s_valid = 1'b1;
        s_data  = 4'd9;
        @(posedge clk);
        #1;
        chk("stall_no_write", 32'(wr_en), 0);
        chk("stall_still", 32'(s_ready), 0);

        // Release bank 0 while sample 9 is still offered (not accepted yet)
        frame_release = 1'b1;
        @(posedge clk);
        #1;
        frame_release = 1'b0;
        s_valid       = 1'b0;
        chk("rel_no_write", 32'(wr_en), 0);
        chk("rel_ready", 32'(s_ready), 1);
        chk("rel_fvalid", 32'(frame_valid), 1);
        chk("rel_fbank", 32'(frame_bank), 1);
        send(4'd9, ea(1'b0, 2'd0));

        // Last word into bank 0 together with release of bank 1
        send(4'd10, ea(1'b0, 2'd1));
        send(4'd11, ea(1'b0, 2'd2));
        s_valid       = 1'b1;
        s_data        = 4'd12;
        frame_release = 1'b1;
        @(posedge clk);
        #1;
        s_valid       = 1'b0;
        frame_release = 1'b0;
        chk("sim0_addr", 32'(wr_address), 32'(ea(1'b0, 2'd3)));
        chk("sim0_ready", 32'(s_ready), 1);
        chk("sim0_fvalid", 32'(frame_valid), 1);
        chk("sim0_fbank", 32'(frame_bank), 0);
        send(4'd13, ea(1'b1, 2'd0));

        // Last word into bank 1 together with release of bank 0
        send(4'd14, ea(1'b1, 2'd1));
        send(4'd15, ea(1'b1, 2'd2));
        s_valid       = 1'b1;
        s_data        = 4'd0;
        frame_release = 1'b1;
        @(posedge clk);
        #1;
        s_valid       = 1'b0;
        frame_release = 1'b0;
        chk("sim1_wr_en", 32'(wr_en), 1);
        chk("sim1_addr", 32'(wr_address), 32'(ea(1'b1, 2'd3)));
        chk("sim1_ready", 32'(s_ready), 1);
        chk("sim1_fvalid", 32'(frame_valid), 1);
        chk("sim1_fbank", 32'(frame_bank), 1);
        send(4'd1, ea(1'b0, 2'd0));

        // Release bank 1 -> nothing full; a further release is ignored
        frame_release = 1'b1;
        @(posedge clk);
        #1;
        chk("empty_fvalid", 32'(frame_valid), 0);
        @(posedge clk);
        #1;
        frame_release = 1'b0;
        chk("ign_fvalid", 32'(frame_valid), 0);
        chk("ign_fbank", 32'(frame_bank), 0);
        chk("ign_ready", 32'(s_ready), 1);

        // Gaps mid-frame keep offsets contiguous
        send(4'd2, ea(1'b0, 2'd1));
        idle(1);
        send(4'd3, ea(1'b0, 2'd2));
        idle(2);
        send(4'd4, ea(1'b0, 2'd3));
        chk("gap_fvalid", 32'(frame_valid), 1);
        chk("gap_fbank", 32'(frame_bank), 0);

        // Reset mid-frame in bank 1
        send(4'd5, ea(1'b1, 2'd0));
        send(4'd6, ea(1'b1, 2'd1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 0);
        chk("mid_rst_addr", 32'(wr_address), 0);
        chk("mid_rst_data", 32'(wr_data), 0);
        chk("mid_rst_fvalid", 32'(frame_valid), 0);
        chk("mid_rst_fbank", 32'(frame_bank), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(s_ready), 1);
        chk("post_rst_wr_en", 32'(wr_en), 0);
        send(4'd7, ea(1'b0, 2'd0));
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_writer.md
FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 word_width, default 4, sample/RAM word width in bits.
REQ-002 address_width, default 3, RAM address width; MSB is bank select, lower address_width-1 bits are frame offset.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 s_valid  input  1  upstream sample valid.
REQ-006 s_ready  output  1  block accepts sample this cycle.
REQ-007 s_data  input  word_width  upstream sample.
REQ-008 wr_en  output  1  RAM write strobe, drives unitRAM wr_en.
REQ-009 wr_address  output  address_width  RAM write address {bank, offset}.
REQ-010 wr_data  output  word_width  RAM write data.
REQ-011 frame_valid  output  1  a full frame is ready for the consumer.
REQ-012 frame_bank  output  1  bank holding the presented frame.
REQ-013 frame_release  input  1  one-cycle pulse; consumer has finished the presented frame.

Function
REQ-014 FRAME = 2**(address_width-1) words per bank; two banks (ping-pong).
REQ-015 Each bank has state FREE, FILLING or FULL; writer FSM states WRITE, STALL.
REQ-016 Transfer occurs on a rising clk edge when s_valid && s_ready.
REQ-017 wr_en, wr_address, wr_data are registered: transfer at edge N gives wr_en=1 with that sample and address during the cycle after edge N, wr_en=0 otherwise.
REQ-018 Offset starts at 0 per bank, increments by 1 per transfer, wraps from FRAME-1 to 0.
REQ-019 Transfer at offset FRAME-1 marks the writing bank FULL; the writer moves to the other bank if FREE (WRITE), else enters STALL.
REQ-020 s_ready = 1 in WRITE, 0 in STALL; s_ready is combinational from registered state only (no s_valid dependency).
REQ-021 frame_valid = 1 whenever any bank is FULL; frame_bank = oldest FULL bank; frame_valid rises the cycle after the last-word transfer.
REQ-022 frame_release while frame_valid=1 sets the frame_bank bank FREE; frame_release while frame_valid=0 is ignored.
REQ-023 STALL exits to WRITE on the cycle after the blocking bank is released; writing resumes at offset 0 of that bank.
REQ-024 Simultaneous last-word transfer into bank X and release of bank Y: both take effect; next cycle writer is in bank Y (WRITE), frame_valid=1, frame_bank=X.
REQ-025 With both banks FULL, release of the older bank leaves frame_valid=1 and frame_bank switches to the other bank on the next cycle.
REQ-026 Samples are never dropped or overwritten; backpressure via s_ready is the only overflow mechanism.

Reset
REQ-027 rst_n low asynchronously forces: both banks FREE, writer in WRITE on bank 0 offset 0, wr_en=0, wr_address=0, wr_data=0, frame_valid=0, frame_bank=0; s_ready=1 after rst_n deasserts.
REQ-028 Reset mid-frame discards the partial frame; no write is issued after reset assertion until a new transfer.

Configuration
REQ-029 Macro FRAME_WRITER_BITREV_EN defined: wr_address offset bits are bit-reversed (bank bit unchanged), so frames land in FFT input order.
REQ-030 Macro undefined: offset is written in natural order; all other behaviour identical.

Structure
REQ-031 Shared package holds bank-state encoding (FREE/FILLING/FULL), writer state encoding (WRITE/STALL) and the bit-reverse function.
REQ-032 No sub-module; block is a single module instantiated directly upstream of unitRAM.

Verification (word_width=4, address_width=3, FRAME=4)
REQ-033 Reset, stream samples 1..4 with s_valid=1 -> wr_address 0,1,2,3 with data 1..4, frame_valid=1, frame_bank=0 one cycle after 4th transfer.
REQ-034 Stream 8 samples, no release -> 8 writes to addresses 0..7, then s_ready=0; release bank 0 -> frame_bank=1 next cycle, s_ready=1, next sample written to address 0.
REQ-035 Last word into bank 1 on same cycle as release of bank 0 -> writer continues at address 0, frame_valid stays 1, frame_bank=1, no stall.
REQ-036 With FRAME_WRITER_BITREV_EN, samples 1..4 -> addresses 0,2,1,3; bank 1 -> 4,6,5,7.
REQ-037 Assert rst_n=0 after 2 transfers -> outputs at reset values immediately; after release, next sample written to address 0.
REQ-038 frame_release pulse with frame_valid=0 -> no state change; s_valid gaps mid-frame -> no wr_en during gaps, offsets contiguous.
